// File: rtl/ripple_carry_adder16.sv
// rtl/ripple_carry_adder16.sv - 16-bit ripple-carry adder built from gate-level full-adder cells, registered outputs
module ripple_carry_adder16 (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] sum,
  output logic        carry_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in
);

  logic [16:0] c;
  logic [15:0] s;

  assign c[0] = carry_in;

  // Each cell is a plain full adder; the carry ripples strictly from bit 0 up to c[16].
  for (genvar i = 0; i < 16; i++) begin : g_cell
    wire p;
    wire g;
    wire t;

    xor u_prop (p, a[i], b[i]);
    xor u_sum  (s[i], p, c[i]);
    and u_gen  (g, a[i], b[i]);
    and u_pass (t, c[i], p);
    or  u_cout (c[i+1], g, t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= 16'h0000;
      carry_out <= 1'b0;
    end else begin
      sum       <= s;
      carry_out <= c[16];
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder16.sv
// tb/tb_ripple_carry_adder16.sv - scoreboard bench for ripple_carry_adder16 against an arithmetic reference
module tb_ripple_carry_adder16;

  logic        clk;
  logic        rst;
  logic [15:0] sum;
  logic        carry_out;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  ripple_carry_adder16 dut (
    .clk       (clk),
    .rst       (rst),
    .sum       (sum),
    .carry_out (carry_out),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got carry_out=%0d sum=%0d, expected carry_out=%0d sum=%0d",
               name, got[16], got[15:0], want[16], want[15:0]);
    end
  endtask

  // Reference: the 17-bit unsigned sum of the three inputs.
  task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic vc);
    logic [16:0] r;
    @(negedge clk);
    a        = va;
    b        = vb;
    carry_in = vc;
    r = 17'(va) + 17'(vb) + 17'(vc);
    exp_q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("result", {carry_out, sum}, exp_q.pop_front());
    end
  end

  initial begin
    int wait_cycles;
    rst      = 1'b1;
    a        = 16'h0;
    b        = 16'h0;
    carry_in = 1'b0;
    #1;
    check("reset_initial", {carry_out, sum}, 17'h0);

    repeat (3) begin
      @(negedge clk);
      a        = 16'($urandom);
      b        = 16'($urandom);
      carry_in = 1'($urandom);
      #1;
      check("reset_hold", {carry_out, sum}, 17'h0);
    end

    @(negedge clk);
    rst      = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    carry_in = 1'b0;
    exp_q.push_back(17'h0);

    apply(16'd1,     16'd1,     1'b1);
    apply(16'd0,     16'd0,     1'b1);
    apply(16'd65535, 16'd1,     1'b0);
    apply(16'd49151, 16'd65535, 1'b0);
    apply(16'd65535, 16'd65535, 1'b0);
    apply(16'd65535, 16'd65535, 1'b1);
    apply(16'd65535, 16'd65535, 1'b0);

    // Short reset pulse between edges while the same operands stay on the inputs.
    apply(16'd65535, 16'd65535, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_pulse", {carry_out, sum}, 17'h0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        @(negedge clk);
        rst = 1'b1;
        a   = 16'hffff;
        b   = 16'hffff;
        #1;
        check("reset_mid_stream", {carry_out, sum}, 17'h0);
        @(posedge clk);
        #1;
        check("reset_across_edge", {carry_out, sum}, 17'h0);
        @(negedge clk);
        rst = 1'b0;
      end
      apply(16'($urandom), 16'($urandom), 1'($urandom));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
